// File: rtl/impulse_convolver.sv
// Impulse-response convolver: keeps a circular history of input samples and
// multiply-accumulates it against coefficients fetched from the impulse memory.
module impulse_convolver #(
  parameter int unsigned MAX_TAPS     = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned OUT_SHIFT    = 15
) (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        audio_trigger,
  input  logic [15:0] audio_in,
  input  logic        impulse_ready,
  input  logic [15:0] impulse_length,
  output logic [15:0] coeff_addr,
  input  logic [15:0] coeff_data,
  output logic [15:0] audio_out,
  output logic        audio_out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned AW = $clog2(MAX_TAPS);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned DW = $clog2(READ_LATENCY + 2);
  localparam int unsigned RW = ACC_WIDTH - OUT_SHIFT;
  localparam logic signed [RW-1:0] SAT_MAX = RW'(32'sd32767);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-32'sd32768);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_PASS,
    S_RUN,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t                       r_state;
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_base;
  logic [AW-1:0]                r_clr_addr;
  logic [NW-1:0]                r_n;
  logic [DW-1:0]                r_drain;
  logic [15:0]                  r_coeff_addr;
  logic [15:0]                  r_audio_out;
  logic                         r_valid;
  logic                         r_busy;
  logic                         r_overrun;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [READ_LATENCY-1:0]      r_vld_pipe;
  logic signed [31:0]           r_prod;
  logic                         r_prod_vld;

  logic signed [15:0]           r_mem [MAX_TAPS];
  logic signed [15:0]           r_hist_pipe [READ_LATENCY];

  logic                         w_accept;
  logic                         w_issue;
  logic                         w_we;
  logic [AW-1:0]                w_waddr;
  logic [15:0]                  w_wdata;
  logic [AW-1:0]                w_raddr;
  logic [NW-1:0]                w_n_clamped;
  logic signed [15:0]           w_coeff_s;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic signed [RW-1:0]         w_res;
  logic [15:0]                  w_sat;

  assign w_accept    = (r_state == S_IDLE) && audio_trigger;
  assign w_issue     = (r_state == S_RUN);
  assign w_we        = (r_state == S_CLEAR) || w_accept;
  assign w_waddr     = (r_state == S_CLEAR) ? r_clr_addr : r_wr_ptr;
  assign w_wdata     = (r_state == S_CLEAR) ? 16'd0 : audio_in;
  assign w_raddr     = r_base - r_coeff_addr[AW-1:0];
  assign w_n_clamped = (impulse_length > 16'(MAX_TAPS)) ? NW'(MAX_TAPS) : NW'(impulse_length);
  assign w_coeff_s   = $signed(coeff_data);
  assign w_shift     = r_acc >>> OUT_SHIFT;
  assign w_res       = $signed(w_shift[RW-1:0]);

  always_comb begin
    w_sat = 16'(w_res);
    if (w_res > SAT_MAX) begin
      w_sat = 16'h7fff;
    end else if (w_res < SAT_MIN) begin
      w_sat = 16'h8000;
    end
  end

  // History RAM (read-first) plus delay line aligning reads with coeff_data
  always_ff @(posedge audio_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_hist_pipe[0] <= r_mem[w_raddr];
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_hist_pipe[i] <= r_hist_pipe[i-1];
    end
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_vld_pipe <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_vld_pipe <= READ_LATENCY'({r_vld_pipe, w_issue});
      r_prod_vld <= r_vld_pipe[READ_LATENCY-1];
      r_prod     <= 32'(w_coeff_s) * 32'(r_hist_pipe[READ_LATENCY-1]);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= S_CLEAR;
      r_wr_ptr     <= '0;
      r_base       <= '0;
      r_clr_addr   <= '0;
      r_n          <= '0;
      r_drain      <= '0;
      r_coeff_addr <= '0;
      r_audio_out  <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b1;
      r_overrun    <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= audio_trigger && (r_state != S_IDLE);
      if (r_prod_vld) begin
        r_acc <= r_acc + ACC_WIDTH'(r_prod);
      end
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == AW'(MAX_TAPS - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (audio_trigger) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_base       <= r_wr_ptr;
            r_n          <= w_n_clamped;
            r_acc        <= '0;
            r_coeff_addr <= '0;
            r_busy       <= 1'b1;
            if (!impulse_ready || (w_n_clamped == '0)) begin
              r_audio_out <= audio_in;
              r_valid     <= 1'b1;
              r_state     <= S_PASS;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_PASS: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_RUN: begin
          if (r_coeff_addr == (16'(r_n) - 16'd1)) begin
            r_coeff_addr <= '0;
            r_drain      <= '0;
            r_state      <= S_DRAIN;
          end else begin
            r_coeff_addr <= r_coeff_addr + 16'd1;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == DW'(READ_LATENCY + 1)) begin
            r_audio_out <= w_sat;
            r_valid     <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign coeff_addr      = r_coeff_addr;
  assign audio_out       = r_audio_out;
  assign audio_out_valid = r_valid;
  assign busy            = r_busy;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_impulse_convolver.sv
// Directed bench for impulse_convolver: table of single-sample transactions
// plus hand-written reset, overrun and length-latch sequences.
module tb_impulse_convolver;

  logic        audio_clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        audio_trigger = 1'b0;
  logic [15:0] audio_in = '0;
  logic        impulse_ready = 1'b0;
  logic [15:0] impulse_length = '0;
  logic [15:0] coeff_addr;
  logic [15:0] coeff_data = '0;
  logic [15:0] audio_out;
  logic        audio_out_valid;
  logic        busy;
  logic        overrun;

  logic signed [15:0] coef_mem [1024];
  logic [15:0]        coef_d1 = '0;

  int n_total = 0;
  int n_pass  = 0;

  impulse_convolver dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .audio_trigger   (audio_trigger),
    .audio_in        (audio_in),
    .impulse_ready   (impulse_ready),
    .impulse_length  (impulse_length),
    .coeff_addr      (coeff_addr),
    .coeff_data      (coeff_data),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .busy            (busy),
    .overrun         (overrun)
  );

  initial forever #5 audio_clk = ~audio_clk;

  // Impulse memory model with a two-cycle registered read
  always @(posedge audio_clk) begin
    coef_d1    <= coef_mem[coeff_addr[9:0]];
    coeff_data <= coef_d1;
  end

  typedef struct {
    int cset;
    bit ready;
    int len;
    int smp;
    int exp_out;
    bit chk_out;
    int exp_lat;
    int exp_maxa;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic load_cset(input int id);
    for (int j = 0; j < 1024; j++) coef_mem[j] = 16'sd0;
    case (id)
      1: coef_mem[0] = 16'sd16384;
      2: coef_mem[3] = 16'sd16384;
      3: for (int j = 0; j < 8; j++) coef_mem[j] = 16'sd32767;
      4: begin coef_mem[0] = 16'sd16384; coef_mem[1] = 16'sd16384; end
      default: ;
    endcase
  endtask

  // Hold reset, check reset outputs, release and time the clear phase
  task automatic do_reset(input string tag);
    int cnt, ovr, vld;
    rst_in = 1'b1;
    audio_trigger = 1'b0;
    repeat (2) @(negedge audio_clk);
    check({tag, "_rst_out"}, audio_out, 0);
    check({tag, "_rst_valid"}, audio_out_valid, 0);
    check({tag, "_rst_overrun"}, overrun, 0);
    check({tag, "_rst_addr"}, coeff_addr, 0);
    check({tag, "_rst_busy"}, busy, 1);
    rst_in = 1'b0;
    cnt = 0; ovr = 0; vld = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge audio_clk);
      cnt = k;
      if (overrun) ovr++;
      if (audio_out_valid) vld++;
      if (k == 10) begin audio_trigger = 1'b1; audio_in = 16'd999; end
      if (k == 11) audio_trigger = 1'b0;
      if (!busy) break;
    end
    audio_trigger = 1'b0;
    check({tag, "_clear_cycles"}, cnt, 1024);
    check({tag, "_clear_overrun"}, ovr, 1);
    check({tag, "_clear_valid"}, vld, 0);
  endtask

  task automatic do_sample(input logic [15:0] smp, input int exp_lat, input int exp_out,
                           input bit chk_out, input int exp_maxa, input string name);
    int lat, pulses, maxa;
    logic [15:0] got;
    lat = -1; pulses = 0; maxa = 0; got = '0;
    audio_in = smp;
    audio_trigger = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge audio_clk);
      if (k == 1) audio_trigger = 1'b0;
      if (int'(coeff_addr) > maxa) maxa = int'(coeff_addr);
      if (audio_out_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; got = audio_out; end
      end
      if (lat > 0 && k > lat && !busy) break;
    end
    audio_trigger = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_pulses"}, pulses, 1);
    check({name, "_maxaddr"}, maxa, exp_maxa);
    check({name, "_hold"}, audio_out, got);
    if (chk_out) check({name, "_out"}, $signed(got), exp_out);
  endtask

  initial begin
    int cur, lat, ovr, vld, cnt;
    logic [15:0] got;

    // cset, ready, len, sample, expected out, check out, latency, max coeff_addr
    vecs[0]  = '{2, 1'b1, 4, 100, 0, 1'b1, 9, 3};
    vecs[1]  = '{2, 1'b1, 4, 200, 0, 1'b1, 9, 3};
    vecs[2]  = '{2, 1'b1, 4, 300, 0, 1'b1, 9, 3};
    vecs[3]  = '{2, 1'b1, 4, 400, 50, 1'b1, 9, 3};
    vecs[4]  = '{2, 1'b1, 4, 500, 100, 1'b1, 9, 3};
    vecs[5]  = '{1, 1'b0, 1, 1234, 1234, 1'b1, 1, 0};
    vecs[6]  = '{1, 1'b1, 0, -77, -77, 1'b1, 1, 0};
    vecs[7]  = '{1, 1'b1, 1, 1000, 500, 1'b1, 6, 0};
    vecs[8]  = '{1, 1'b1, 1, -3, -2, 1'b1, 6, 0};
    vecs[9]  = '{1, 1'b1, 2000, 2000, 1000, 1'b1, 1029, 1023};
    for (int i = 10; i < 17; i++) vecs[i] = '{3, 1'b1, 8, 32767, 0, 1'b0, 13, 7};
    vecs[17] = '{3, 1'b1, 8, 32767, 32767, 1'b1, 13, 7};
    for (int i = 18; i < 25; i++) vecs[i] = '{3, 1'b1, 8, -32768, 0, 1'b0, 13, 7};
    vecs[25] = '{3, 1'b1, 8, -32768, -32768, 1'b1, 13, 7};

    for (int j = 0; j < 1024; j++) coef_mem[j] = 16'sd0;
    do_reset("por");

    cur = 0;
    for (int i = 0; i < 26; i++) begin
      if (vecs[i].cset != cur) begin
        load_cset(vecs[i].cset);
        cur = vecs[i].cset;
      end
      impulse_ready  = vecs[i].ready;
      impulse_length = 16'(vecs[i].len);
      do_sample(16'(vecs[i].smp), vecs[i].exp_lat, vecs[i].exp_out, vecs[i].chk_out,
                vecs[i].exp_maxa, $sformatf("v%0d", i));
    end

    // Reset in the middle of a long computation restarts the clear phase
    load_cset(1);
    impulse_ready = 1'b1;
    impulse_length = 16'd50;
    audio_in = 16'd5;
    audio_trigger = 1'b1;
    @(negedge audio_clk);
    audio_trigger = 1'b0;
    repeat (5) @(negedge audio_clk);
    do_reset("midrun");

    // Overrun during RUN plus mid-run length change
    load_cset(4);
    impulse_length = 16'd64;
    audio_in = 16'd800;
    audio_trigger = 1'b1;
    lat = -1; ovr = 0; vld = 0; cnt = 0; got = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge audio_clk);
      cnt = k;
      if (k == 1) audio_trigger = 1'b0;
      if (k == 10) begin audio_trigger = 1'b1; audio_in = 16'd2000; end
      if (k == 11) audio_trigger = 1'b0;
      if (k == 20) impulse_length = 16'd2;
      if (overrun) ovr++;
      if (audio_out_valid) begin
        vld++;
        if (lat < 0) begin lat = k; got = audio_out; end
      end
      if (lat > 0 && k > lat && !busy) break;
    end
    audio_trigger = 1'b0;
    check("ovr_latency", lat, 69);
    check("ovr_out", $signed(got), 400);
    check("ovr_pulses", ovr, 1);
    check("ovr_valid_count", vld, 1);
    check("ovr_idle_after", cnt, 70);
    do_sample(16'd600, 7, 700, 1'b1, 1, "after_drop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
